// File: rtl/pic_loader.sv
// Pixel-stream loader for the picture RAM: packs pixel pairs into words, writes them
// through port A, and holds a completed image until the core signals it is done.
module pic_loader #(
  parameter int PIX_W  = 8,
  parameter int DW     = 16,
  parameter int AW     = 14,
  parameter int NWORDS = 392
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [AW-1:0]    pic_addr,
  output logic [DW-1:0]    pic_data,
  output logic             pic_we,
  output logic             pic_ready,
  input  logic             pic_get_finish,
  output logic             err_len
);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_LAST = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [AW:0] PIX_TERM = (AW+1)'(2*NWORDS-1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [AW:0]      pix_cnt;
  logic [PIX_W-1:0] low_byte;
  logic             accept;
  logic             odd_pix;
  logic             term_pix;

  assign accept   = s_valid && s_ready;
  assign odd_pix  = pix_cnt[0];
  assign term_pix = (pix_cnt == PIX_TERM);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: if (accept && term_pix) state_nxt = ST_LAST;
      ST_LAST: state_nxt = ST_HOLD;
      ST_HOLD: if (pic_get_finish) state_nxt = ST_FILL;
      default: state_nxt = ST_FILL;
    endcase
  end

  // The word counter is the pixel counter halved, so a single counter tracks both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt  <= '0;
      low_byte <= '0;
    end else if (state == ST_FILL && accept) begin
      if (!odd_pix) low_byte <= s_data;
      if (term_pix) begin
        pix_cnt <= pix_cnt;
      end else if (s_last) begin
        pix_cnt <= '0;
      end else begin
        pix_cnt <= pix_cnt + CNT_ONE;
      end
    end else if (state == ST_HOLD && pic_get_finish) begin
      pix_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      s_ready   <= 1'b1;
      pic_ready <= 1'b0;
      pic_we    <= 1'b0;
      pic_addr  <= '0;
      pic_data  <= '0;
      err_len   <= 1'b0;
    end else begin
      state     <= state_nxt;
      s_ready   <= (state_nxt == ST_FILL);
      pic_ready <= (state_nxt == ST_HOLD);
      pic_we    <= 1'b0;
      err_len   <= 1'b0;
      if (state == ST_FILL && accept) begin
        // An early last on an even pixel still flushes the half-filled word.
        if (odd_pix) begin
          pic_we   <= 1'b1;
          pic_addr <= pix_cnt[AW:1];
          pic_data <= {s_data, low_byte};
        end else if (s_last) begin
          pic_we   <= 1'b1;
          pic_addr <= pix_cnt[AW:1];
          pic_data <= {{PIX_W{1'b0}}, s_data};
        end
        if (term_pix) err_len <= !s_last;
        else if (s_last) err_len <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pic_loader.sv
// Scoreboard bench for pic_loader: stimulus queues expected RAM writes, a negedge
// monitor pops and compares them whenever pic_we is seen.
module tb_pic_loader;

  localparam int AW   = 14;
  localparam int DW   = 16;
  localparam int NPIX = 784;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [AW-1:0] pic_addr;
  logic [DW-1:0] pic_data;
  logic          pic_we;
  logic          pic_ready;
  logic          pic_get_finish = 1'b0;
  logic          err_len;

  always #5 clk = ~clk;

  pic_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .pic_addr       (pic_addr),
    .pic_data       (pic_data),
    .pic_we         (pic_we),
    .pic_ready      (pic_ready),
    .pic_get_finish (pic_get_finish),
    .err_len        (err_len)
  );

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_word;
  logic [AW+DW-1:0] last_write = '0;
  int total = 0;
  int passed = 0;
  int writes_seen = 0;
  int err_seen = 0;
  int err_with_we = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_len) begin
        err_seen++;
        if (pic_we) err_with_we++;
      end
      if (pic_we) begin
        writes_seen++;
        last_write = {pic_addr, pic_data};
        if (exp_q.size() == 0) begin
          checkOutput("write_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_word = exp_q.pop_front();
          checkOutput("write_addr_data", 32'({pic_addr, pic_data}), 32'(exp_word));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic last, input int gap_pct);
    int  waited;
    bit  done;
    if (gap_pct > 0) begin
      while ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    waited  = 0;
    done    = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end else begin
        waited++;
        if (waited >= 200) begin
          checkOutput("accept_timeout", 32'(s_ready), 32'd1);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic doMidReset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_pic_we", 32'(pic_we), 32'd0);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
    checkOutput("rst_pic_ready", 32'(pic_ready), 32'd0);
    checkOutput("rst_err_len", 32'(err_len), 32'd0);
    checkOutput("rst_addr_data", 32'({pic_addr, pic_data}), 32'd0);
    checkOutput("rst_queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic sendImage(input int n, input int last_idx, input int base,
                           input int gap_pct, input int reset_pix);
    logic [7:0] p;
    logic [7:0] low;
    low = '0;
    for (int i = 0; i < n; i++) begin
      p = 8'((i + base) & 255);
      if (i % 2 == 1) exp_q.push_back({14'(i / 2), p, low});
      else if (i == last_idx) exp_q.push_back({14'(i / 2), 8'h00, p});
      if (i % 2 == 0) low = p;
      applyStimulus(p, (i == last_idx), gap_pct);
      if (i == reset_pix) begin
        doMidReset();
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic expectReadyRise(input string tag);
    @(negedge clk);
    checkOutput({tag, "_final_we"}, 32'(pic_we), 32'd1);
    checkOutput({tag, "_ready_not_yet"}, 32'(pic_ready), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_ready_rise"}, 32'(pic_ready), 32'd1);
    checkOutput({tag, "_sready_low"}, 32'(s_ready), 32'd0);
    checkOutput({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic releaseHold(input string tag);
    s_valid = 1'b0;
    pic_get_finish = 1'b1;
    @(posedge clk); #1;
    pic_get_finish = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_release_ready"}, 32'(pic_ready), 32'd0);
    checkOutput({tag, "_release_sready"}, 32'(s_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int e0;
    int w0;
    int hi;

    #2 rst_n = 1'b0;
    #20;
    checkOutput("reset_s_ready", 32'(s_ready), 32'd1);
    checkOutput("reset_outputs", 32'({pic_we, pic_ready, err_len}), 32'd0);
    checkOutput("reset_addr_data", 32'({pic_addr, pic_data}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] test 1: ramp image");
    e0 = err_seen; w0 = writes_seen;
    sendImage(NPIX, NPIX - 1, 0, 0, -1);
    expectReadyRise("ramp");
    checkOutput("ramp_writes", 32'(writes_seen - w0), 32'd392);
    checkOutput("ramp_last_write", 32'(last_write), {2'b0, 14'd391, 16'h0F0E});
    checkOutput("ramp_no_err", 32'(err_seen - e0), 32'd0);

    $display("[TB] test 2: hold with backpressure");
    w0 = writes_seen; hi = 0;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (s_ready) hi++;
    end
    @(posedge clk); #1;
    checkOutput("hold_sready_cycles", 32'(hi), 32'd0);
    checkOutput("hold_no_writes", 32'(writes_seen - w0), 32'd0);
    checkOutput("hold_ready_held", 32'(pic_ready), 32'd1);
    releaseHold("hold");

    $display("[TB] test 3: early last on odd index");
    e0 = err_seen; w0 = writes_seen;
    sendImage(10, 9, 8'h30, 0, -1);
    repeat (5) @(negedge clk);
    checkOutput("early9_writes", 32'(writes_seen - w0), 32'd5);
    checkOutput("early9_err", 32'(err_seen - e0), 32'd1);
    checkOutput("early9_no_ready", 32'(pic_ready), 32'd0);
    checkOutput("early9_sready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    e0 = err_seen;
    sendImage(NPIX, NPIX - 1, 8'h11, 0, -1);
    expectReadyRise("after_early");
    checkOutput("after_early_no_err", 32'(err_seen - e0), 32'd0);
    releaseHold("after_early");

    $display("[TB] test 4: early last on even index");
    e0 = err_seen; w0 = writes_seen;
    sendImage(5, 4, 8'hC0, 0, -1);
    repeat (3) @(negedge clk);
    checkOutput("early4_writes", 32'(writes_seen - w0), 32'd3);
    checkOutput("early4_partial", 32'(last_write), {2'b0, 14'd2, 16'h00C4});
    checkOutput("early4_err", 32'(err_seen - e0), 32'd1);
    checkOutput("early4_no_ready", 32'(pic_ready), 32'd0);
    @(posedge clk); #1;

    $display("[TB] test 5: missing last");
    e0 = err_seen; w0 = err_with_we;
    sendImage(NPIX, -1, 0, 0, -1);
    expectReadyRise("nolast");
    checkOutput("nolast_err", 32'(err_seen - e0), 32'd1);
    checkOutput("nolast_err_with_we", 32'(err_with_we - w0), 32'd1);
    checkOutput("nolast_last_write", 32'(last_write), {2'b0, 14'd391, 16'h0F0E});
    releaseHold("nolast");

    $display("[TB] test 6: gaps then reset mid-image");
    sendImage(NPIX, NPIX - 1, 8'h55, 30, 401);
    w0 = writes_seen; e0 = err_seen;
    sendImage(NPIX, NPIX - 1, 8'h7F, 0, -1);
    expectReadyRise("post_reset");
    checkOutput("post_reset_writes", 32'(writes_seen - w0), 32'd392);
    checkOutput("post_reset_no_err", 32'(err_seen - e0), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
